// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte producers.
// Each accepted byte is handed to the transmitter with a one-cycle tx_start.
// The arbiter then waits for tx_done before it accepts another byte.
// A byte with req_last=0 locks the grant to its requester until the last byte
// of the message arrives. If that requester stays quiet for LOCK_TO cycles,
// the lock is released.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int D_W     = 8,
  parameter int LOCK_TO = 1024,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*D_W-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [D_W-1:0]     tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic [ID_W-1:0]    grant_id,
  output logic               locked,
  output logic               busy
);

  localparam int CNT_W = $clog2(LOCK_TO) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  grant_id_reg, grant_id_next;
  logic [D_W-1:0]   tx_data_reg, tx_data_next;
  logic             locked_reg, locked_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_REQ-1:0] req_ready_int;

  logic [D_W-1:0]   req_bytes [N_REQ];
  logic             rr_found;
  logic [ID_W-1:0]  rr_winner;
  logic [ID_W-1:0]  rr_idx;

  // Split the flat data bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*D_W +: D_W];
    end
  endgenerate

  // Round-robin search. The scan starts just after the last grant and wraps,
  // so the most recently served requester has the lowest priority.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = ID_W'((int'(grant_id_reg) + k) % N_REQ);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  // Next-state logic, the acceptance handshake and the lock timeout counter.
  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    tx_data_next  = tx_data_reg;
    locked_next   = locked_reg;
    cnt_next      = cnt_reg;
    req_ready_int = '0;
    case (state_reg)
      S_IDLE: begin
        if (!tx_busy && rr_found) begin
          req_ready_int[rr_winner] = 1'b1;
          tx_data_next  = req_bytes[rr_winner];
          grant_id_next = rr_winner;
          locked_next   = ~req_last[rr_winner];
          state_next    = S_START;
        end
      end
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (tx_done) state_next = locked_reg ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        if (req_valid[grant_id_reg] && !tx_busy) begin
          req_ready_int[grant_id_reg] = 1'b1;
          tx_data_next = req_bytes[grant_id_reg];
          locked_next  = ~req_last[grant_id_reg];
          cnt_next     = '0;
          state_next   = S_START;
        end else if (cnt_reg == CNT_W'(LOCK_TO - 1)) begin
          // The requester went quiet in the middle of a message.
          // Release the lock, but keep grant_id so that round-robin
          // continues after this requester.
          locked_next = 1'b0;
          cnt_next    = '0;
          state_next  = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A byte accepted while reset is high would be lost, so hold ready low.
    if (reset) req_ready_int = '0;
  end

  // State register with synchronous reset. Requester 0 gets first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      grant_id_reg <= ID_W'(N_REQ - 1);
      tx_data_reg  <= '0;
      locked_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      tx_data_reg  <= tx_data_next;
      locked_reg   <= locked_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign req_ready = req_ready_int;
  assign tx_start  = (state_reg == S_START);
  assign tx_data   = tx_data_reg;
  assign grant_id  = grant_id_reg;
  assign locked    = locked_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit datapath (uart_tx, driven by the baud_gen tick) between N_REQ byte producers.
- Arbitrates round-robin among requesters and sequences each byte into the transmitter (start pulse, wait for done).
- Supports multi-byte message locking (req_last) with a lock-release timeout.
- Sits between the on-chip producers and the uart_tx instance in the uart top.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- D_W, 8, data bits per frame; matches uart_tx D_W.
- LOCK_TO, 1024, idle cycles allowed while locked before forced lock release (>=1).
- ID_W, $clog2(N_REQ), width of grant_id.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  N_REQ*D_W  per-requester byte; requester i at bits [i*D_W +: D_W]
- req_last  in  N_REQ  byte is the last of its message; sampled with the accepted byte
- req_ready  out  N_REQ  one-hot or zero; byte of requester i accepted this cycle
- tx_start  out  1  one-cycle pulse; uart_tx begins frame with tx_data
- tx_data  out  D_W  registered byte presented to uart_tx, stable from tx_start until tx_done
- tx_busy  in  1  uart_tx frame in progress
- tx_done  in  1  one-cycle pulse; uart_tx finished stop bit
- grant_id  out  ID_W  index of the current or last granted requester
- locked  out  1  grant locked to grant_id mid-message
- busy  out  1  arbiter not in IDLE

Behaviour:
- Clocking: single clock domain clk; all state updates on the rising edge. Reset is synchronous and active-high.
- Reset values:
  - tx_start=0, tx_data=0, grant_id=N_REQ-1 (requester 0 has first priority), locked=0, busy=0.
  - req_ready=0; FSM in IDLE; timeout counter=0.
- Handshake:
  - A byte transfers on a cycle where req_valid[i] && req_ready[i].
  - req_ready is combinational from state, req_valid, grant_id and tx_busy; never asserted for a requester with req_valid=0.
  - Requesters hold req_data and req_last stable while valid and not ready.
- FSM states:
  - IDLE: if tx_busy=0 and any req_valid, select the winner as the first set bit searching from grant_id+1 upward, wrapping modulo N_REQ. Assert req_ready[winner]. Register tx_data<=byte and grant_id<=winner. Set locked<=~req_last[winner]. Go to START. If none are valid, or tx_busy=1, stay.
  - START: tx_start=1 for exactly this cycle. Go to WAIT.
  - WAIT: hold tx_data. On tx_done: go to LOCKED if locked=1, else IDLE. tx_done is ignored in every other state.
  - LOCKED: only grant_id may transfer. If req_valid[grant_id]=1 and tx_busy=0: assert req_ready[grant_id], load tx_data, set locked<=~req_last, clear the counter, go to START. Otherwise increment the counter. When the counter reaches LOCK_TO-1 with no transfer: locked<=0, counter<=0, go to IDLE. grant_id is unchanged, so round-robin resumes after it.
- Latency:
  - Acceptance happens in the same cycle req_valid is seen in IDLE or LOCKED.
  - tx_start follows acceptance by exactly 1 cycle.
  - After tx_done, the next acceptance occurs no earlier than the following cycle.
- Fairness: the grant pointer moves only on acceptance. With all requesters continuously valid and req_last=1, grants cycle 0,1,2,3,0,...
- Lock interaction: while locked, other requesters are stalled (req_ready=0) regardless of their valid.
- Timeout: the counter is ID-independent, sized $clog2(LOCK_TO)+1, and is active only in LOCKED.
- Reset mid-frame: the arbiter returns to IDLE immediately. The datapath is reset by the same reset; no tx_start is issued during or in the cycle after reset.
- Out-of-protocol input: tx_busy=1 in IDLE blocks arbitration until it deasserts.

Test Plan:
- Single request: after reset, req_valid=0001 with data 0x55 and last=1 → req_ready=0001 same cycle; tx_start 1 cycle later with tx_data=0x55. After tx_done, busy=0 and grant_id=0.
- Round-robin: all four valid, last=1, data i→0xA0+i, tx_done 10 cycles after each start → tx_data sequence A0,A1,A2,A3,A0; each req_ready one-hot.
- Message lock: requester 2 sends 0x11(last=0), 0x22(last=0), 0x33(last=1) while requester 1 is held valid → all three bytes go out before requester 1 gets req_ready; locked=1 between bytes and 0 after 0x33.
- Lock timeout (LOCK_TO=8): requester 3 sends last=0, then drops valid; requester 0 is valid → after tx_done plus 8 LOCKED cycles, locked=0 and requester 0 is granted next cycle.
- Busy/stray done: tx_busy=1 in IDLE with requests pending → no req_ready until tx_busy=0. A tx_done pulse in IDLE or START → no state change.
- Reset mid-operation: assert reset in WAIT → next cycle all outputs at reset values, grant_id=N_REQ-1; requester 0 wins the first arbitration after release.
